// File: rtl/frame_tx16.sv
// Byte-serial framer: each accepted 16-bit word goes out as HEAD, high byte, low byte
// with cs low, followed by GAP idle cycles; a one-word buffer queues the next word.
module frame_tx16 #(
    parameter logic [7:0] HEAD = 8'hCA,
    parameter int         GAP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] d_in,
    output logic        rdy,
    output logic        cs,
    output logic [7:0]  d_out,
    output logic        done,
    output logic [7:0]  cnt
);

    typedef enum logic [2:0] {IDLE, HDR, HI, LO, GAPW} state_t;

    localparam logic [3:0] GAP_RELOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [15:0] sh, sh_nxt;
    logic [15:0] hold, hold_nxt;
    logic        buf_valid, buf_nxt;
    logic [3:0]  gcnt, gcnt_nxt;
    logic [7:0]  cnt_nxt;
    logic        cs_nxt, done_nxt;
    logic [7:0]  d_out_nxt;
    logic        acc;

    assign rdy = !buf_valid;

    always_comb begin
        acc       = req && !buf_valid;
        state_nxt = state;
        sh_nxt    = sh;
        hold_nxt  = hold;
        buf_nxt   = buf_valid;
        gcnt_nxt  = gcnt;
        cnt_nxt   = cnt;

        if (acc && state != IDLE) begin
            hold_nxt = d_in;
            buf_nxt  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (acc) begin
                    sh_nxt    = d_in;
                    state_nxt = HDR;
                end else if (buf_valid) begin
                    // A word may land in the buffer on the very edge a frame ends
                    sh_nxt    = hold;
                    buf_nxt   = 1'b0;
                    state_nxt = HDR;
                end
            end
            HDR: state_nxt = HI;
            HI:  state_nxt = LO;
            LO: begin
                cnt_nxt = cnt + 8'd1;
                if (GAP > 0) begin
                    gcnt_nxt  = GAP_RELOAD;
                    state_nxt = GAPW;
                end else if (buf_valid) begin
                    sh_nxt    = hold;
                    buf_nxt   = 1'b0;
                    state_nxt = HDR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAPW: begin
                if (gcnt == 4'd0) begin
                    if (buf_valid) begin
                        sh_nxt    = hold;
                        buf_nxt   = 1'b0;
                        state_nxt = HDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gcnt_nxt = gcnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so derive them from the state being entered
        cs_nxt    = 1'b1;
        d_out_nxt = 8'h00;
        done_nxt  = 1'b0;
        case (state_nxt)
            HDR: begin
                cs_nxt    = 1'b0;
                d_out_nxt = HEAD;
            end
            HI: begin
                cs_nxt    = 1'b0;
                d_out_nxt = sh_nxt[15:8];
            end
            LO: begin
                cs_nxt    = 1'b0;
                d_out_nxt = sh_nxt[7:0];
                done_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh        <= 16'h0000;
            hold      <= 16'h0000;
            buf_valid <= 1'b0;
            gcnt      <= 4'd0;
            cnt       <= 8'd0;
            cs        <= 1'b1;
            d_out     <= 8'h00;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            hold      <= hold_nxt;
            buf_valid <= buf_nxt;
            gcnt      <= gcnt_nxt;
            cnt       <= cnt_nxt;
            cs        <= cs_nxt;
            d_out     <= d_out_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_frame_tx16.sv
// Directed bench for frame_tx16: one GAP=1 and one GAP=0 instance share stimulus.
module tb_frame_tx16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] d_in = 16'h0000;

    logic       rdy1, cs1, done1, rdy0, cs0, done0;
    logic [7:0] dout1, cnt1, dout0, cnt0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    frame_tx16 #(.HEAD(8'hCA), .GAP(1)) u_gap1 (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in),
        .rdy(rdy1), .cs(cs1), .d_out(dout1), .done(done1), .cnt(cnt1)
    );

    frame_tx16 #(.HEAD(8'hCA), .GAP(0)) u_gap0 (
        .clk(clk), .rst(rst), .req(req), .d_in(d_in),
        .rdy(rdy0), .cs(cs0), .d_out(dout0), .done(done0), .cnt(cnt0)
    );

    // Advance one edge; outputs are then sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cs1, dout1, rdy1, done1, cnt1} !== {1'b1, 8'h00, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_gap1[%0d]: cs=%b d_out=%h rdy=%b done=%b cnt=%h, want 1 00 1 0 00",
                         k, cs1, dout1, rdy1, done1, cnt1);
            end
            checks++;
            if ({cs0, dout0, rdy0, done0, cnt0} !== {1'b1, 8'h00, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_gap0[%0d]: cs=%b d_out=%h rdy=%b done=%b cnt=%h, want 1 00 1 0 00",
                         k, cs0, dout0, rdy0, done0, cnt0);
            end
            rst = 1'b0;
            tick();
        end
    endtask

    task automatic test_single_gap1();
        logic       exp_cs   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_dout [5] = '{8'hCA, 8'h12, 8'h34, 8'h00, 8'h00};
        logic       exp_done [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req  = 1'b1;
        d_in = 16'h1234;
        tick();
        req  = 1'b0;
        d_in = 16'hFFFF;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({cs1, dout1, done1} !== {exp_cs[k], exp_dout[k], exp_done[k]}) begin
                errors++;
                $display("FAIL single_gap1[%0d]: cs=%b d_out=%h done=%b, want %b %h %b",
                         k, cs1, dout1, done1, exp_cs[k], exp_dout[k], exp_done[k]);
            end
            if (k == 3) begin
                checks++;
                if (cnt1 !== 8'd1) begin
                    errors++;
                    $display("FAIL single_gap1_cnt: cnt=%0d, want 1", cnt1);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_cs   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_dout [7] = '{8'hCA, 8'hAB, 8'hCD, 8'hCA, 8'h00, 8'h01, 8'h00};
        logic       exp_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        req  = 1'b1;
        d_in = 16'hABCD;
        tick();
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({cs0, dout0, rdy0} !== {exp_cs[k], exp_dout[k], exp_rdy[k]}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: cs=%b d_out=%h rdy=%b, want %b %h %b",
                         k, cs0, dout0, rdy0, exp_cs[k], exp_dout[k], exp_rdy[k]);
            end
            if (k == 0) d_in = 16'h0001;
            else req = 1'b0;
            tick();
        end
        checks++;
        if (cnt0 !== 8'd2) begin
            errors++;
            $display("FAIL back_to_back_cnt: cnt=%0d, want 2", cnt0);
        end
    endtask

    task automatic test_buffer_full();
        logic [7:0] exp_dout [6] = '{8'hCA, 8'h11, 8'h11, 8'hCA, 8'h22, 8'h22};
        int dones;
        int low_after;
        do_reset();
        req  = 1'b1;
        d_in = 16'h1111;
        tick();
        dones = 0;
        low_after = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 6) begin
                checks++;
                if ({cs0, dout0} !== {1'b0, exp_dout[k]}) begin
                    errors++;
                    $display("FAIL buffer_full_byte[%0d]: cs=%b d_out=%h, want 0 %h",
                             k, cs0, dout0, exp_dout[k]);
                end
            end else if (cs0 == 1'b0) begin
                low_after++;
            end
            if (done0) dones++;
            if (k == 0) d_in = 16'h2222;
            else if (k == 1) d_in = 16'h3333;
            else req = 1'b0;
            tick();
        end
        checks++;
        if (dones != 2 || low_after != 0 || cnt0 !== 8'd2) begin
            errors++;
            $display("FAIL buffer_full_frames: dones=%0d extra_cs_low=%0d cnt=%0d, want 2 0 2",
                     dones, low_after, cnt0);
        end
    endtask

    task automatic test_reset_mid_frame();
        req  = 1'b1;
        d_in = 16'h5A5A;
        tick();
        req  = 1'b0;
        tick();
        checks++;
        if ({cs0, dout0} !== {1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL mid_frame_hi: cs=%b d_out=%h, want 0 5a", cs0, dout0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cs0, dout0, rdy0, done0, cnt0} !== {1'b1, 8'h00, 1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL mid_frame_reset[%0d]: cs=%b d_out=%h rdy=%b done=%b cnt=%h, want 1 00 1 0 00",
                         k, cs0, dout0, rdy0, done0, cnt0);
            end
            tick();
        end
    endtask

    task automatic test_cnt_wrap();
        int dones;
        int gaps;
        do_reset();
        dones = 0;
        gaps  = 0;
        req   = 1'b1;
        for (int i = 0; i < 768; i++) begin
            d_in = 16'(i);
            tick();
            if (cs0 !== 1'b0) gaps++;
            if (done0 === 1'b1) dones++;
        end
        req = 1'b0;
        tick();
        checks++;
        if (dones != 256 || gaps != 0) begin
            errors++;
            $display("FAIL cnt_wrap_stream: dones=%0d idle_cycles=%0d, want 256 0", dones, gaps);
        end
        checks++;
        if (cnt0 !== 8'h00) begin
            errors++;
            $display("FAIL cnt_wrap_value: cnt=%h, want 00", cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single_gap1();
        test_back_to_back();
        test_buffer_full();
        test_reset_mid_frame();
        test_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
